// File: rtl/job_sequencer.sv
// Host-side job controller: loads a job's input bytes into data memory, starts the core,
// waits for done (with timeout), then streams the result bytes back out.
module job_sequencer #(
    parameter int unsigned AW        = 8,
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned LOAD_LEN  = 30,
    parameter int unsigned RES_BASE  = 30,
    parameter int unsigned RES_LEN   = 30,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_dat,
    input  logic [7:0]    mem_rd_dat,
    output logic          core_req,
    input  logic          core_done,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          timeout_err,
    output logic [15:0]   cycle_cnt
);

    localparam int unsigned IW = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;
    localparam int unsigned JW = (RES_LEN > 1) ? $clog2(RES_LEN) : 1;

    localparam logic [IW-1:0] ILast   = IW'(LOAD_LEN - 1);
    localparam logic [JW-1:0] JLast   = JW'(RES_LEN - 1);
    localparam logic [15:0]   CntLast = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {StLoad, StStart, StRun, StUnload, StErr} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] load_addr, res_addr;

    assign load_addr = AW'(LOAD_BASE) + AW'(i_q);
    assign res_addr  = AW'(RES_BASE) + AW'(j_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StLoad;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_dat  = '0;
        core_req    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        timeout_err = 1'b0;
        cycle_cnt   = cnt_q;

        unique case (state_q)
            StLoad: begin
                in_ready   = 1'b1;
                mem_addr   = load_addr;
                mem_wr_dat = in_data;
                mem_wr_en  = in_valid;
                if (in_valid) begin
                    if (i_q == ILast) begin
                        i_d     = '0;
                        state_d = StStart;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            StStart: begin
                busy     = 1'b1;
                core_req = 1'b1;
                cnt_d    = '0;
                state_d  = StRun;
            end
            StRun: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 16'd1;
                // cnt_q == 0 marks the first RUN cycle, where a stale done may still be visible
                if (core_done && (cnt_q != '0)) begin
                    state_d = StUnload;
                end else if (cnt_q == CntLast) begin
                    state_d = StErr;
                end
            end
            StUnload: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                mem_addr  = res_addr;
                out_data  = mem_rd_dat;
                if (out_ready) begin
                    if (j_q == JLast) begin
                        j_d     = '0;
                        state_d = StLoad;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            StErr: begin
                timeout_err = 1'b1;
            end
            default: begin
                state_d = StLoad;
            end
        endcase

        // Reset is sampled on the edge, so gate outputs to zero for the whole reset window
        if (!reset) begin
            in_ready    = 1'b0;
            mem_wr_en   = 1'b0;
            mem_addr    = '0;
            mem_wr_dat  = '0;
            core_req    = 1'b0;
            out_valid   = 1'b0;
            out_data    = '0;
            busy        = 1'b0;
            timeout_err = 1'b0;
            cycle_cnt   = '0;
        end
    end

endmodule

// File: doc/job_sequencer.md
# job_sequencer

Host-side job controller that sits directly upstream of the processor top level. It streams a job's input bytes into data memory over a valid/ready byte interface, then starts the core with `core_req`. It waits for the core's `done` flag, with a timeout, and then streams the result bytes back out of data memory. It owns the data-memory write/address port whenever the core is not running.

## Interface
Parameters:
- `AW`, 8: data-memory address width.
- `LOAD_BASE`, 0: first address written with input bytes.
- `LOAD_LEN`, 30: input bytes per job; must be ≥1 and ≤2^AW.
- `RES_BASE`, 30: first result address read back.
- `RES_LEN`, 30: result bytes per job; must be ≥1 and ≤2^AW.
- `TIMEOUT`, 4096: maximum RUN cycles; must be ≥2 and ≤65535.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input byte.
- `in_ready` out 1: block accepts an input byte this cycle.
- `mem_wr_en` out 1: data-memory write strobe.
- `mem_addr` out AW: data-memory address.
- `mem_wr_dat` out 8: data-memory write data.
- `mem_rd_dat` in 8: data-memory read data, combinational from `mem_addr`.
- `core_req` out 1: one-cycle start pulse to the core.
- `core_done` in 1: core completion flag (level).
- `out_valid` out 1: result byte valid.
- `out_data` out 8: result byte.
- `out_ready` in 1: consumer accepts the result byte.
- `busy` out 1: high in START, RUN and UNLOAD.
- `timeout_err` out 1: sticky timeout flag.
- `cycle_cnt` out 16: number of RUN cycles in the last or current job.

## Operation
- States: LOAD, START, RUN, UNLOAD, ERR. Reset state is LOAD.
- Two index counters, `i` (load) and `j` (unload), each wide enough for LOAD_LEN/RES_LEN. Both clear on reset and on entry to their state.
- LOAD
  - `in_ready`=1; `mem_addr` = LOAD_BASE+i (mod 2^AW); `mem_wr_dat` = `in_data`.
  - `mem_wr_en` = `in_valid` (combinational; writes in the accept cycle).
  - Each accept increments `i`. The accept with `i`==LOAD_LEN-1 moves to START.
- START
  - `core_req`=1 for exactly this cycle; `cycle_cnt` cleared to 0; next state RUN.
- RUN
  - `cycle_cnt` increments every cycle.
  - `core_done` is ignored in the first RUN cycle, because a stale done may persist until the core's PC restarts. From the second RUN cycle on, `core_done`=1 moves to UNLOAD.
  - Otherwise, when `cycle_cnt` reaches TIMEOUT-1, the next state is ERR.
  - If done and timeout coincide, done wins and the next state is UNLOAD.
- UNLOAD
  - `mem_addr` = RES_BASE+j (mod 2^AW); `out_valid`=1; `out_data` = `mem_rd_dat`.
  - `out_data` is held stable while `out_ready`=0.
  - Each `out_valid&out_ready` handshake increments `j`. The handshake with `j`==RES_LEN-1 returns to LOAD for the next job.
- ERR
  - `timeout_err`=1 and held.
  - `in_ready`, `out_valid`, `core_req` and `mem_wr_en` are all 0.
  - Only reset exits ERR.
- Outside LOAD: `in_ready`=0 and `in_valid` is ignored; `mem_wr_en`=0. Outside UNLOAD: `out_valid`=0.
- `mem_addr`=0 in START, RUN and ERR, so the core's port has no contention.
- `cycle_cnt` holds its value outside RUN until the next START.

## Timing
- While `reset`=0, all outputs are 0; on the first cycle after release the state is LOAD with `in_ready`=1.
- A reset asserted in any state aborts the job: back to LOAD, `i`, `j` and `cycle_cnt` cleared, `timeout_err` cleared. A partially loaded job is discarded.
- Last input accepted in cycle k: `core_req`=1 in cycle k+1, RUN starts at k+2.
- `core_done` sampled high in cycle r (r ≥ second RUN cycle): `out_valid`=1 at r+1.
- With `out_ready` held at 1, one result byte per cycle. The last handshake in cycle u gives `in_ready`=1 at u+1.
- A job of N RUN cycles reports `cycle_cnt`=N.

## Test plan
- Basic job: load bytes 0x01..0x1E; stub core asserts done 10 cycles after `core_req` → exactly 30 writes at addresses 0..29, one `core_req` pulse, `cycle_cnt`=10, then 30 output bytes read from addresses 30..59 in order.
- Backpressure: toggle `in_valid` and `out_ready` at random → no byte dropped or duplicated, `out_data` stable while stalled, `in_ready` low outside LOAD.
- Stale done: `core_done` held 1 before and during START → first RUN cycle ignored, UNLOAD entered after the second RUN cycle, `cycle_cnt`=2.
- Timeout: TIMEOUT=16, core never done → ERR after 16 RUN cycles, `timeout_err`=1 held, all strobes 0 until reset.
- Done on the timeout cycle: `core_done` rises in RUN cycle 16 with TIMEOUT=16 → UNLOAD, `timeout_err`=0.
- Reset mid-UNLOAD after 5 bytes → all outputs 0 during reset, then LOAD with `in_ready`=1; next job unloads from RES_BASE.
